// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: state encoding, parity modes and config clamp bounds shared by the
// configurable UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_CLEANUP = 3'd5
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_DATA_BITS    = 5;
  localparam int MIN_CLKS_PER_BIT = 2;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (req > max_bits) return max_bits;
    return req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// uart_baud_tick: loadable down-counter that strobes tick on the last cycle of
// every bit period while run is high; the period is captured on load.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 run,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] reload;
  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= '0;
      count  <= '0;
    end else if (load) begin
      reload <= period - DIV_WIDTH'(1);
      count  <= period - DIV_WIDTH'(1);
    end else if (run) begin
      if (count == '0) count <= reload;
      else             count <= count - DIV_WIDTH'(1);
    end
  end

  assign tick = run && (count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// uart_tx_cfg: run-time configurable UART transmitter (5-9 data bits, even/odd
// parity, 1/2 stop bits, run-time divisor) with RS-485 driver enable.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 48_000_000,
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_WIDTH     = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic [DIV_WIDTH-1:0]     i_Clks_Per_Bit,
  input  logic [3:0]               i_Data_Bits,
  input  logic [1:0]               i_Parity,
  input  logic                     i_Stop_Bits,
  input  logic                     i_Tx_DV,
  input  logic [MAX_DATA_BITS-1:0] i_Tx_Byte,
  output logic                     o_Tx_Ready,
  output logic                     o_Tx_Active,
  output logic                     o_Tx_Serial,
  output logic                     o_Tx_Enable,
  output logic                     o_Tx_Done
);

  generate
    if (MAX_DATA_BITS < 5 || MAX_DATA_BITS > 9 || CLK_FREQ_HZ < 1) begin : g_bad_params
      $error("uart_tx_cfg: MAX_DATA_BITS must be 5..9 and CLK_FREQ_HZ positive");
    end
  endgenerate

  uart_state_t              state;
  logic [MAX_DATA_BITS-1:0] data_sr;
  logic [3:0]               nbits;
  logic [3:0]               bit_idx;
  logic [1:0]               par_mode;
  logic                     two_stop;
  logic                     second_stop;
  logic                     par_acc;

  logic                 accept;
  logic                 bit_run;
  logic                 tick;
  logic [DIV_WIDTH-1:0] cpb_clamped;

  assign accept      = (state == ST_IDLE) && i_Tx_DV;
  assign bit_run     = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_PARITY) || (state == ST_STOP);
  assign cpb_clamped = (i_Clks_Per_Bit < DIV_WIDTH'(MIN_CLKS_PER_BIT)) ?
                       DIV_WIDTH'(MIN_CLKS_PER_BIT) : i_Clks_Per_Bit;

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk    (i_Clock),
    .rst    (i_Reset),
    .load   (accept),
    .period (cpb_clamped),
    .run    (bit_run),
    .tick   (tick)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      o_Tx_Serial <= 1'b1;
      o_Tx_Ready  <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Enable <= 1'b0;
      o_Tx_Done   <= 1'b0;
      data_sr     <= '0;
      nbits       <= 4'(MIN_DATA_BITS);
      bit_idx     <= 4'd0;
      par_mode    <= PAR_NONE;
      two_stop    <= 1'b0;
      second_stop <= 1'b0;
      par_acc     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Done   <= 1'b0;
          if (i_Tx_DV) begin
            data_sr     <= i_Tx_Byte;
            nbits       <= clamp_data_bits(i_Data_Bits, 4'(MAX_DATA_BITS));
            par_mode    <= i_Parity;
            two_stop    <= i_Stop_Bits;
            second_stop <= 1'b0;
            par_acc     <= 1'b0;
            bit_idx     <= 4'd0;
            o_Tx_Serial <= 1'b0;
            o_Tx_Ready  <= 1'b0;
            o_Tx_Active <= 1'b1;
            o_Tx_Enable <= 1'b1;
            state       <= ST_START;
          end else begin
            o_Tx_Ready <= 1'b1;
          end
        end

        ST_START: begin
          if (tick) begin
            o_Tx_Serial <= data_sr[0];
            par_acc     <= data_sr[0];
            data_sr     <= {1'b0, data_sr[MAX_DATA_BITS-1:1]};
            state       <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (tick) begin
            // par_acc already covers every data bit once the last one is on the line
            if (bit_idx == nbits - 4'd1) begin
              if (par_mode == PAR_EVEN || par_mode == PAR_ODD) begin
                o_Tx_Serial <= par_acc ^ (par_mode == PAR_ODD);
                state       <= ST_PARITY;
              end else begin
                o_Tx_Serial <= 1'b1;
                state       <= ST_STOP;
              end
            end else begin
              o_Tx_Serial <= data_sr[0];
              par_acc     <= par_acc ^ data_sr[0];
              data_sr     <= {1'b0, data_sr[MAX_DATA_BITS-1:1]};
              bit_idx     <= bit_idx + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            o_Tx_Serial <= 1'b1;
            state       <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (two_stop && !second_stop) begin
              second_stop <= 1'b1;
            end else begin
              o_Tx_Active <= 1'b0;
              o_Tx_Enable <= 1'b0;
              o_Tx_Done   <= 1'b1;
              state       <= ST_CLEANUP;
            end
          end
        end

        ST_CLEANUP: begin
          o_Tx_Done  <= 1'b0;
          o_Tx_Ready <= 1'b1;
          state      <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          o_Tx_Serial <= 1'b1;
          o_Tx_Ready  <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Enable <= 1'b0;
          o_Tx_Done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// tb_uart_tx_cfg: frame-level reference model compared every cycle, plus
// directed frames with hand-computed line patterns and latencies.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clks_per_bit = 16'd4;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity = 2'b00;
  logic        stop_bits = 1'b0;
  logic        tx_dv = 1'b0;
  logic [8:0]  tx_byte = 9'd0;
  logic        tx_ready, tx_active, tx_serial, tx_enable, tx_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .CLK_FREQ_HZ  (48_000_000),
    .MAX_DATA_BITS(9),
    .DIV_WIDTH    (16)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Clks_Per_Bit(clks_per_bit),
    .i_Data_Bits   (data_bits),
    .i_Parity      (parity),
    .i_Stop_Bits   (stop_bits),
    .i_Tx_DV       (tx_dv),
    .i_Tx_Byte     (tx_byte),
    .o_Tx_Ready    (tx_ready),
    .o_Tx_Active   (tx_active),
    .o_Tx_Serial   (tx_serial),
    .o_Tx_Enable   (tx_enable),
    .o_Tx_Done     (tx_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected output tuple per clock cycle.
  typedef struct packed {
    logic ser;
    logic act;
    logic rdy;
    logic dn;
  } exp_t;

  localparam exp_t IDLE_E = '{ser: 1'b1, act: 1'b0, rdy: 1'b1, dn: 1'b0};

  exp_t q[$];
  exp_t cur = IDLE_E;

  task automatic push_frame();
    int   cpb;
    int   d;
    logic p;
    logic lv[$];
    cpb = (clks_per_bit < 16'd2) ? 2 : int'(clks_per_bit);
    d   = (data_bits < 4'd5) ? 5 : ((data_bits > 4'd9) ? 9 : int'(data_bits));
    p   = 1'b0;
    lv.push_back(1'b0);
    for (int i = 0; i < d; i++) begin
      lv.push_back(tx_byte[i]);
      p = p ^ tx_byte[i];
    end
    if (parity == 2'b01) lv.push_back(p);
    else if (parity == 2'b10) lv.push_back(~p);
    lv.push_back(1'b1);
    if (stop_bits) lv.push_back(1'b1);
    foreach (lv[j])
      for (int c = 0; c < cpb; c++) q.push_back('{ser: lv[j], act: 1'b1, rdy: 1'b0, dn: 1'b0});
    q.push_back('{ser: 1'b1, act: 1'b0, rdy: 1'b0, dn: 1'b1});
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        cur = IDLE_E;
      end else begin
        if (cur.rdy && tx_dv) push_frame();
        if (q.size() > 0) cur = q.pop_front();
        else cur = IDLE_E;
      end
    end
  end

  always @(negedge clk) begin
    chk("serial", 32'(tx_serial), 32'(cur.ser));
    chk("active", 32'(tx_active), 32'(cur.act));
    chk("enable", 32'(tx_enable), 32'(cur.act));
    chk("ready",  32'(tx_ready),  32'(cur.rdy));
    chk("done",   32'(tx_done),   32'(cur.dn));
  end

  // Sends one word; fb[b] is the line level on the first cycle of frame bit b.
  // Config is scrambled and a stray request pulsed while the frame is in flight.
  task automatic send_frame(input logic [8:0] w, input logic [15:0] cpb_in,
                            input logic [3:0] db, input logic [1:0] par, input logic sb,
                            input int cpb_eff, input int nbits,
                            output logic [15:0] fb, output int lat);
    @(negedge clk);
    clks_per_bit = cpb_in;
    data_bits    = db;
    parity       = par;
    stop_bits    = sb;
    tx_byte      = w;
    tx_dv        = 1'b1;
    fb  = '0;
    lat = -1;
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) tx_dv = 1'b0;
      if (k == 2) begin
        clks_per_bit = 16'd7;
        data_bits    = 4'd6;
        parity       = ~par;
        stop_bits    = ~sb;
        tx_byte      = ~w;
      end
      if (k == 3) tx_dv = 1'b1;
      if (k == 4) tx_dv = 1'b0;
      for (int b = 0; b < 16; b++)
        if (b < nbits && k == 1 + b * cpb_eff) fb[b] = tx_serial;
      if (tx_done) lat = k;
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic [15:0] fb;
  int          lat;
  logic        act_hist[80];

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(tx_serial), 32'd1);
    chk("rst_ready",  32'(tx_ready),  32'd1);
    chk("rst_active", 32'(tx_active), 32'd0);
    chk("rst_enable", 32'(tx_enable), 32'd0);
    chk("rst_done",   32'(tx_done),   32'd0);
    #2 rst = 1'b0;

    // CPB=4 8N1 0x55
    send_frame(9'h055, 16'd4, 4'd8, 2'b00, 1'b0, 4, 10, fb, lat);
    chk("t1_bits", 32'(fb), 32'h02AA);
    chk("t1_lat", 32'(lat), 32'd41);
    @(negedge clk);
    chk("t1_ready_after", 32'(tx_ready), 32'd1);

    // CPB=3 7E2 0x03
    send_frame(9'h003, 16'd3, 4'd7, 2'b01, 1'b1, 3, 11, fb, lat);
    chk("t2_bits", 32'(fb), 32'h0606);
    chk("t2_lat", 32'(lat), 32'd34);

    // CPB=2 8O1 0xFF, 8E1 0x01, 5E1 0x1E0
    send_frame(9'h0FF, 16'd2, 4'd8, 2'b10, 1'b0, 2, 11, fb, lat);
    chk("t3a_bits", 32'(fb), 32'h07FE);
    chk("t3a_lat", 32'(lat), 32'd23);
    send_frame(9'h001, 16'd2, 4'd8, 2'b01, 1'b0, 2, 11, fb, lat);
    chk("t3b_bits", 32'(fb), 32'h0602);
    send_frame(9'h1E0, 16'd2, 4'd5, 2'b01, 1'b0, 2, 8, fb, lat);
    chk("t3c_bits", 32'(fb), 32'h0080);
    chk("t3c_lat", 32'(lat), 32'd17);

    // 9N1 via clamps: data bits 15 -> 9, divisor 0 -> 2
    send_frame(9'h1A5, 16'd0, 4'd15, 2'b11, 1'b0, 2, 11, fb, lat);
    chk("t4_bits", 32'(fb), 32'h074A);
    chk("t4_lat", 32'(lat), 32'd23);

    // Back-to-back with a new word and config every cycle
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      act_hist[c]  = tx_active;
      tx_dv        = 1'b1;
      tx_byte      = 9'($urandom);
      data_bits    = 4'($urandom_range(4, 10));
      parity       = 2'($urandom_range(0, 3));
      stop_bits    = 1'($urandom_range(0, 1));
      clks_per_bit = 16'($urandom_range(0, 3));
    end
    tx_dv = 1'b0;
    begin
      int f;
      int r;
      f = -1;
      r = -1;
      for (int c = 1; c < 80; c++) begin
        if (f < 0 && act_hist[c-1] && !act_hist[c]) f = c;
        else if (f >= 0 && r < 0 && !act_hist[c-1] && act_hist[c]) r = c;
      end
      chk("b2b_gap", 32'(r - (f - 1)), 32'd3);
    end
    begin
      bit idle_seen;
      idle_seen = 1'b0;
      for (int k = 0; k < 400 && !idle_seen; k++) begin
        @(negedge clk);
        if (tx_ready) idle_seen = 1'b1;
      end
      if (!idle_seen) chk("b2b_idle_timeout", 32'd0, 32'd1);
    end

    // Reset during data bit 3 of a CPB=4 8N1 frame
    @(negedge clk);
    clks_per_bit = 16'd4;
    data_bits    = 4'd8;
    parity       = 2'b00;
    stop_bits    = 1'b0;
    tx_byte      = 9'h0A5;
    tx_dv        = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_serial", 32'(tx_serial), 32'd1);
    chk("t6_rst_ready",  32'(tx_ready),  32'd1);
    chk("t6_rst_active", 32'(tx_active), 32'd0);
    chk("t6_rst_enable", 32'(tx_enable), 32'd0);
    chk("t6_rst_done",   32'(tx_done),   32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    send_frame(9'h0A5, 16'd4, 4'd8, 2'b00, 1'b0, 4, 10, fb, lat);
    chk("t6_bits", 32'(fb), 32'h034A);
    chk("t6_lat", 32'(lat), 32'd41);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
